freq_div_sched: RTL and testbench

- Time-shares one 3-bit-select frequency divider (8-bit free-running counter; output = count[sel]) among NREQ requesters.
- Round-robin arbitrates the requests and drives the divider's select and reset.
- Holds each grant for a programmed number of divided-output rising edges, then releases the divider.
- Sits directly in front of the divider. Its div_sel and div_rst drive the divider's select input and active-high reset; the divider's output feeds back on div_out.

---
 rtl/freq_div_pkg.sv | 43 ++++
 rtl/freq_div_rr_arb.sv | 22 ++
 rtl/freq_div_sched.sv | 117 +++++++++++
 tb/tb_freq_div_sched.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_div_pkg.sv
// Shared types and helpers for the time-shared frequency divider scheduler.
// Holds the FSM state encoding and the round-robin pick function.
package freq_div_pkg;

    localparam int SEL_W_DEF = 3;
    localparam int DIV_CNT_W = 8;
    localparam int MAX_REQ   = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } pick_t;

    // Search starts just after the last winner and wraps modulo nreq.
    function automatic pick_t rr_pick(
        input logic [MAX_REQ-1:0] req,
        input logic [2:0]         ptr,
        input int                 nreq
    );
        pick_t p;
        int    j;
        p.found = 1'b0;
        p.idx   = 3'd0;
        for (int k = 1; k <= MAX_REQ; k++) begin
            if (k <= nreq && !p.found) begin
                j = (int'(ptr) + k) % nreq;
                if (req[j]) begin
                    p.found = 1'b1;
                    p.idx   = 3'(j);
                end
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/freq_div_rr_arb.sv
// Combinational round-robin picker over NREQ request lines.
// Priority rotates so the requester after ptr is considered first.
module freq_div_rr_arb
    import freq_div_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0] req,
    input  logic [2:0]      ptr,
    output logic            found,
    output logic [2:0]      winner
);

    pick_t pick;

    always_comb begin
        pick   = rr_pick(MAX_REQ'(req), ptr, NREQ);
        found  = pick.found;
        winner = pick.idx;
    end

endmodule

// File: rtl/freq_div_sched.sv
// Round-robin scheduler time-sharing one count[sel] frequency divider.
// Grants are held for a latched number of divided-output rising edges.
module freq_div_sched
    import freq_div_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int SEL_W   = SEL_W_DEF,
    parameter int DWELL_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*SEL_W-1:0] sel_in,
    input  logic [DWELL_W-1:0]    dwell,
    input  logic                  div_out,
    output logic [SEL_W-1:0]      div_sel,
    output logic                  div_rst,
    output logic [NREQ-1:0]       gnt,
    output logic                  busy,
    output logic                  done
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t             state;
    logic [2:0]         ptr;
    logic [IDX_W-1:0]   cur;
    logic [DWELL_W-1:0] dwell_q;
    logic [DWELL_W-1:0] edge_cnt;
    logic               div_out_q;
    logic               found;
    logic [2:0]         winner;
    logic [IDX_W-1:0]   win;
    logic               rise;

    freq_div_rr_arb #(.NREQ(NREQ)) u_arb (
        .req    (req),
        .ptr    (ptr),
        .found  (found),
        .winner (winner)
    );

    assign win  = IDX_W'(winner);
    assign rise = div_out & ~div_out_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            gnt       <= '0;
            div_sel   <= '0;
            div_rst   <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            ptr       <= 3'(NREQ - 1);
            cur       <= '0;
            dwell_q   <= '0;
            edge_cnt  <= '0;
            div_out_q <= 1'b0;
        end else begin
            done      <= 1'b0;
            div_out_q <= div_out;
            unique case (state)
                IDLE: begin
                    div_rst <= 1'b1;
                    gnt     <= '0;
                    busy    <= 1'b0;
                    if (found) begin
                        gnt     <= NREQ'(1) << win;
                        div_sel <= sel_in[int'(win)*SEL_W +: SEL_W];
                        dwell_q <= (dwell == '0) ? DWELL_W'(1) : dwell;
                        ptr     <= winner;
                        cur     <= win;
                        busy    <= 1'b1;
                        state   <= LOAD;
                    end
                end
                LOAD: begin
                    // Divider is still held in reset so its count starts at 0 in RUN.
                    edge_cnt  <= '0;
                    div_out_q <= 1'b0;
                    if (!req[cur]) begin
                        gnt   <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        div_rst <= 1'b0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    if (!req[cur]) begin
                        gnt     <= '0;
                        div_rst <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else if (rise) begin
                        edge_cnt <= edge_cnt + DWELL_W'(1);
                        if (edge_cnt + DWELL_W'(1) == dwell_q) begin
                            gnt     <= '0;
                            div_rst <= 1'b1;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            state   <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_freq_div_sched.sv
// Scoreboard bench for freq_div_sched driving a behavioural count[sel] divider.
// Each grant is checked for owner, select, RUN length, edge count and done.
module tb_freq_div_sched;

    localparam int NREQ    = 4;
    localparam int SEL_W   = 3;
    localparam int DWELL_W = 8;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*SEL_W-1:0] sel_in;
    logic [DWELL_W-1:0]    dwell;
    logic                  div_out;
    logic [SEL_W-1:0]      div_sel;
    logic                  div_rst;
    logic [NREQ-1:0]       gnt;
    logic                  busy;
    logic                  done;

    logic [7:0] div_cnt;

    typedef struct {
        logic [3:0] gnt;
        logic [2:0] sel;
        int         run;
        int         edges;
        logic       done;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    int n_chk  = 0;
    int n_fail = 0;

    int         done_cnt = 0;
    int         viol     = 0;
    bit         active   = 1'b0;
    logic [3:0] m_gnt;
    logic [2:0] m_sel;
    int         m_run;
    int         m_edg;
    int         m_selchg;
    bit         m_prev;

    int ab_e;
    int ab_n;
    bit ab_p;

    freq_div_sched #(
        .NREQ    (NREQ),
        .SEL_W   (SEL_W),
        .DWELL_W (DWELL_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .sel_in  (sel_in),
        .dwell   (dwell),
        .div_out (div_out),
        .div_sel (div_sel),
        .div_rst (div_rst),
        .gnt     (gnt),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (div_rst) div_cnt <= 8'd0;
        else         div_cnt <= div_cnt + 8'd1;
    end

    assign div_out = div_cnt[div_sel];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_done(input int lim);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < lim);
        check("done_seen", 32'(done), 32'd1);
    endtask

    task automatic wait_gnt(input int lim);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (gnt == '0 && n < lim);
        check("gnt_seen", 32'(gnt != '0), 32'd1);
    endtask

    // Per-grant monitor: pops one expectation whenever a grant ends.
    always @(negedge clk) begin
        if (!rst) begin
            active = 1'b0;
        end else begin
            if (done) done_cnt++;
            if (!$onehot0(gnt)) viol++;
            if (!active && gnt != '0) begin
                active   = 1'b1;
                m_gnt    = gnt;
                m_sel    = div_sel;
                m_run    = 0;
                m_edg    = 0;
                m_selchg = 0;
                m_prev   = 1'b0;
            end else if (active && gnt != '0) begin
                if (div_sel != m_sel) m_selchg++;
                if (!div_rst) begin
                    m_run++;
                    if (div_out && !m_prev) m_edg++;
                    m_prev = div_out;
                end else begin
                    m_prev = 1'b0;
                end
            end else if (active && gnt == '0) begin
                active = 1'b0;
                if (sb.size() == 0) begin
                    check("sb_empty", 32'd0, 32'd1);
                end else begin
                    e = sb.pop_front();
                    check("gnt_owner", 32'(m_gnt), 32'(e.gnt));
                    check("div_sel", 32'(m_sel), 32'(e.sel));
                    check("sel_stable", 32'(m_selchg), 32'd0);
                    check("edges", 32'(m_edg), 32'(e.edges));
                    check("done_end", 32'(done), 32'(e.done));
                    check("rst_end", 32'(div_rst), 32'd1);
                    check("busy_end", 32'(busy), 32'd0);
                    check("onehot", 32'(viol), 32'd0);
                    if (e.run >= 0) check("run_len", 32'(m_run), 32'(e.run));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst    = 1'b0;
        req    = '0;
        sel_in = '0;
        dwell  = '0;
        repeat (3) @(negedge clk);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_div_rst", 32'(div_rst), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_div_sel", 32'(div_sel), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // single request, sel 0, dwell 3
        dwell = 8'd3;
        sb.push_back('{gnt: 4'b0001, sel: 3'd0, run: 6, edges: 3, done: 1'b1});
        req = 4'b0001;
        @(posedge clk);
        #1;
        check("latency_gnt", 32'(gnt), 32'b0001);
        wait_done(100);
        check("done_gnt0", 32'(gnt), 32'd0);
        req = '0;
        @(negedge clk);

        // slow divide, inputs changed mid-grant must be ignored
        sel_in[6 +: 3] = 3'd1;
        dwell = 8'd2;
        sb.push_back('{gnt: 4'b0100, sel: 3'd1, run: 7, edges: 2, done: 1'b1});
        req = 4'b0100;
        @(posedge clk);
        #1;
        sel_in[6 +: 3] = 3'd5;
        dwell = 8'd9;
        wait_done(100);
        req = '0;
        @(negedge clk);

        // asynchronous reset in the middle of RUN
        sel_in = '0;
        sel_in[0 +: 3] = 3'd3;
        dwell = 8'd5;
        req = 4'b0001;
        wait_gnt(20);
        repeat (4) @(negedge clk);
        check("mid_busy", 32'(busy), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("arst_gnt", 32'(gnt), 32'd0);
        check("arst_div_rst", 32'(div_rst), 32'd1);
        check("arst_done", 32'(done), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_div_sel", 32'(div_sel), 32'd0);
        req = '0;
        @(negedge clk);
        #2;
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_gnt", 32'(gnt), 32'd0);

        // round robin from the reset pointer
        sel_in = '0;
        dwell = 8'd1;
        sb.push_back('{gnt: 4'b0001, sel: 3'd0, run: 2, edges: 1, done: 1'b1});
        sb.push_back('{gnt: 4'b0010, sel: 3'd0, run: 2, edges: 1, done: 1'b1});
        sb.push_back('{gnt: 4'b0100, sel: 3'd0, run: 2, edges: 1, done: 1'b1});
        sb.push_back('{gnt: 4'b1000, sel: 3'd0, run: 2, edges: 1, done: 1'b1});
        sb.push_back('{gnt: 4'b0001, sel: 3'd0, run: 2, edges: 1, done: 1'b1});
        req = 4'b1111;
        for (int i = 0; i < 5; i++) wait_done(50);
        req = '0;
        @(negedge clk);

        // abandon after the second rising edge
        sel_in[3 +: 3] = 3'd2;
        dwell = 8'd4;
        sb.push_back('{gnt: 4'b0010, sel: 3'd2, run: -1, edges: 2, done: 1'b0});
        req = 4'b0010;
        ab_e = 0;
        ab_n = 0;
        ab_p = 1'b0;
        while (ab_e < 2 && ab_n < 400) begin
            @(negedge clk);
            ab_n++;
            if (gnt != '0 && !div_rst) begin
                if (div_out && !ab_p) ab_e++;
                ab_p = div_out;
            end else begin
                ab_p = 1'b0;
            end
        end
        check("ab_edges", 32'(ab_e), 32'd2);
        req = '0;
        @(posedge clk);
        #1;
        check("ab_gnt", 32'(gnt), 32'd0);
        check("ab_div_rst", 32'(div_rst), 32'd1);
        check("ab_done", 32'(done), 32'd0);
        @(negedge clk);

        // pointer sits on requester 1, so requester 0 wins next
        sel_in = '0;
        dwell = 8'd1;
        sb.push_back('{gnt: 4'b0001, sel: 3'd0, run: 2, edges: 1, done: 1'b1});
        req = 4'b0011;
        wait_done(50);
        req = '0;
        @(negedge clk);

        // dwell of zero behaves as one
        dwell = 8'd0;
        sb.push_back('{gnt: 4'b0001, sel: 3'd0, run: 2, edges: 1, done: 1'b1});
        req = 4'b0001;
        wait_done(50);
        req = '0;
        repeat (3) @(negedge clk);

        check("sb_left", 32'(sb.size()), 32'd0);
        check("done_total", 32'(done_cnt), 32'd9);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
